// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory bus between instruction fetch (port 1) and data access (port 2).
// Define MEM_ARB_IPRIO_EN to let the fetch port win ties; by default the data port wins.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              memValid1,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    output logic [DATA_W-1:0] d_rdata,
    output logic              memValid2,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [1:0]        m_size,
    output logic              m_sign,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    // state  | meaning
    // IDLE   | pick a pending port, issue it; zero-wait ack stays here
    // LOCK_I | fetch access outstanding, fields held until m_ack
    // LOCK_D | data access outstanding, fields held until m_ack
    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t            state, state_nxt;
    logic              done_i, done_d;
    logic [DATA_W-1:0] i_cap, d_cap;
    logic              d_req, pend_i, pend_d;
    logic              grant_i, grant_d;
    logic              ack_i, ack_d, advance;

    assign d_req  = d_rd | d_wr;
    assign pend_i = i_rd & ~done_i;
    assign pend_d = d_req & ~done_d;

    always_comb begin
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef MEM_ARB_IPRIO_EN
                grant_i = pend_i;
                grant_d = pend_d & ~pend_i;
`else
                grant_d = pend_d;
                grant_i = pend_i & ~pend_d;
`endif
                if ((grant_i | grant_d) && !m_ack)
                    state_nxt = grant_d ? LOCK_D : LOCK_I;
            end
            LOCK_I: begin
                grant_i = 1'b1;
                if (m_ack) state_nxt = IDLE;
            end
            LOCK_D: begin
                grant_d = 1'b1;
                if (m_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset gates the request combinationally so an in-flight lock is dropped at once.
    assign m_req   = ~reset & (grant_i | grant_d);
    assign m_we    = grant_d & d_wr;
    assign m_addr  = grant_d ? d_addr : i_addr;
    assign m_wdata = d_wdata;
    assign m_size  = grant_d ? d_size : 2'd2;
    assign m_sign  = grant_d & d_sign;

    assign ack_i = m_req & m_ack & grant_i;
    assign ack_d = m_req & m_ack & grant_d;

    assign memValid1 = reset | ~i_rd | done_i | ack_i;
    assign memValid2 = reset | ~d_req | done_d | ack_d;
    assign advance   = memValid1 & memValid2;

    assign i_rdata = ack_i ? m_rdata : i_cap;
    assign d_rdata = ack_d ? (d_wr ? '0 : m_rdata) : d_cap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            done_i <= 1'b0;
            done_d <= 1'b0;
            i_cap  <= '0;
            d_cap  <= '0;
        end else begin
            state  <= state_nxt;
            done_i <= ~advance & (done_i | ack_i);
            done_d <= ~advance & (done_d | ack_d);
            if (ack_i) i_cap <= m_rdata;
            if (ack_d) d_cap <= d_wr ? '0 : m_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed per-cycle checks plus a bus-access scoreboard.
// Expected tie order follows MEM_ARB_IPRIO_EN when defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rd;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        memValid1;
    logic        d_rd, d_wr;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;
    logic [31:0] d_rdata;
    logic        memValid2;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic        m_sign;
    logic        m_ack;
    logic [31:0] m_rdata;

`ifdef MEM_ARB_IPRIO_EN
    localparam bit IPRIO = 1'b1;
`else
    localparam bit IPRIO = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  size;
    } acc_t;

    acc_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .memValid1(memValid1),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sign(d_sign), .d_rdata(d_rdata), .memValid2(memValid2),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_size(m_size), .m_sign(m_sign), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [1:0] sz);
        acc_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.size = sz;
        q.push_back(e);
    endtask

    task automatic quiet();
        i_rd = 0; d_rd = 0; d_wr = 0; m_ack = 0; m_rdata = '0;
    endtask

    // Scoreboard: every completed bus access is matched against the expected order.
    always @(negedge clk) begin
        if (!reset && m_req && m_ack) begin
            if (q.size() == 0) begin
                chk("sb_extra_access", {32'h0, m_addr}, 64'hFFFF_FFFF);
            end else begin
                acc_t e;
                e = q.pop_front();
                chk("sb_addr", m_addr, e.addr);
                chk("sb_we", m_we, e.we);
                chk("sb_size", m_size, e.size);
                if (e.we) chk("sb_wdata", m_wdata, e.wdata);
            end
        end
    end

    initial begin
        logic [31:0] win_addr, lose_addr;
        reset = 1; quiet();
        i_addr = 32'h100; d_addr = '0; d_wdata = '0; d_size = 2'd2; d_sign = 0;
        i_rd = 1; m_ack = 1;
        mid();
        chk("rst_m_req", m_req, 0);
        chk("rst_valid1", memValid1, 1);
        chk("rst_valid2", memValid2, 1);
        tick(); tick();
        reset = 0; quiet();

        // fetch only, zero wait
        i_rd = 1; i_addr = 32'h100; m_ack = 1; m_rdata = 32'h0050_0093;
        push(32'h100, 0, '0, 2'd2);
        mid();
        chk("f0_m_req", m_req, 1);
        chk("f0_m_addr", m_addr, 32'h100);
        chk("f0_valid1", memValid1, 1);
        chk("f0_rdata", i_rdata, 32'h0050_0093);
        tick();
        quiet(); m_ack = 1; m_rdata = 32'hFFFF;
        mid();
        chk("stray_ack_m_req", m_req, 0);
        chk("stray_ack_hold", i_rdata, 32'h0050_0093);
        tick();

        // tie between fetch and data read
        quiet();
        i_rd = 1; i_addr = 32'h104; d_rd = 1; d_addr = 32'h2000; d_size = 2'd2;
        m_ack = 1; m_rdata = 32'hAAAA;
        win_addr  = IPRIO ? 32'h104 : 32'h2000;
        lose_addr = IPRIO ? 32'h2000 : 32'h104;
        push(win_addr, 0, '0, 2'd2);
        push(lose_addr, 0, '0, 2'd2);
        mid();
        chk("tie_n_addr", m_addr, win_addr);
        chk("tie_n_valid1", memValid1, IPRIO);
        chk("tie_n_valid2", memValid2, !IPRIO);
        tick();
        m_rdata = 32'h1234;
        mid();
        chk("tie_n1_addr", m_addr, lose_addr);
        chk("tie_n1_valid1", memValid1, 1);
        chk("tie_n1_valid2", memValid2, 1);
        chk("tie_n1_d_rdata", d_rdata, IPRIO ? 32'h1234 : 32'hAAAA);
        chk("tie_n1_i_rdata", i_rdata, IPRIO ? 32'hAAAA : 32'h1234);
        tick();

        // store with three wait cycles
        quiet();
        d_wr = 1; d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
        push(32'h3000, 1, 32'hDEAD_BEEF, 2'd2);
        for (int k = 0; k < 4; k++) begin
            m_ack = (k == 3);
            mid();
            chk("st_m_req", m_req, 1);
            chk("st_m_we", m_we, 1);
            chk("st_m_addr", m_addr, 32'h3000);
            chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
            chk("st_valid2", memValid2, (k == 3));
            if (k == 3) chk("st_d_rdata", d_rdata, 0);
            tick();
        end

        // reset while locked on a data read
        quiet();
        d_rd = 1; d_addr = 32'h3000; d_size = 2'd2;
        mid();
        chk("rl_issue", m_req, 1);
        tick();
        mid();
        chk("rl_lock_req", m_req, 1);
        chk("rl_lock_valid2", memValid2, 0);
        tick();
        reset = 1;
        mid();
        chk("rl_rst_m_req", m_req, 0);
        chk("rl_rst_valid2", memValid2, 1);
        tick();
        reset = 0; m_ack = 1; m_rdata = 32'h55;
        push(32'h3000, 0, '0, 2'd2);
        mid();
        chk("rl_reissue_req", m_req, 1);
        chk("rl_reissue_addr", m_addr, 32'h3000);
        chk("rl_valid2", memValid2, 1);
        chk("rl_d_rdata", d_rdata, 32'h55);
        chk("rl_i_cap_cleared", i_rdata, 0);
        tick();

        // winner acked at once, loser waits two extra cycles; no re-grant of winner
        quiet();
        i_rd = 1; i_addr = 32'h200; d_rd = 1; d_addr = 32'h2400;
        win_addr  = IPRIO ? 32'h200 : 32'h2400;
        lose_addr = IPRIO ? 32'h2400 : 32'h200;
        push(win_addr, 0, '0, 2'd2);
        push(lose_addr, 0, '0, 2'd2);
        m_ack = 1; m_rdata = 32'h77;
        mid();
        chk("ng_c0_addr", m_addr, win_addr);
        tick();
        m_ack = 0;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("ng_wait_addr", m_addr, lose_addr);
            chk("ng_wait_win_valid", IPRIO ? memValid1 : memValid2, 1);
            chk("ng_wait_lose_valid", IPRIO ? memValid2 : memValid1, 0);
            tick();
        end
        m_ack = 1; m_rdata = 32'h88;
        mid();
        chk("ng_adv_valid1", memValid1, 1);
        chk("ng_adv_valid2", memValid2, 1);
        tick();
        // winner's request still high after the advance: a fresh access starts
        if (IPRIO) i_rd = 1'b1; else d_rd = 1'b1;
        if (IPRIO) d_rd = 1'b0; else i_rd = 1'b0;
        m_ack = 0;
        push(win_addr, 0, '0, 2'd2);
        mid();
        chk("ng_fresh_req", m_req, 1);
        chk("ng_fresh_addr", m_addr, win_addr);
        chk("ng_fresh_valid", IPRIO ? memValid1 : memValid2, 0);
        tick();
        m_ack = 1; m_rdata = 32'h99;
        mid();
        tick();
        quiet();
        tick();

        chk("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
